mux_sel_rr_arbiter: RTL

//  Round-robin arbiter that shares one 32:1 single-bit mux (5-bit select) among 32 requesters.

---
 rtl/mux_arb_pkg.sv | 29 ++
 rtl/rr_pick.sv | 50 +++++
 rtl/mux_sel_rr_arbiter.sv | 128 ++++++++++++
 3 files changed

// File: rtl/mux_arb_pkg.sv
// +----------------------------------------------------------------------+
// | mux_arb_pkg : shared sizes, state encoding and helpers for the arbiter |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
`default_nettype none

package mux_arb_pkg;

  localparam int N            = 32;
  localparam int SELW         = 5;
  localparam int DEF_MAX_HOLD = 8;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Hold counter must represent MAX_HOLD itself; never narrower than one bit.
  function automatic int hold_w(input int max_hold);
    int w;
    w = $clog2(max_hold + 1);
    return (w < 1) ? 1 : w;
  endfunction

  localparam int HOLDW = hold_w(DEF_MAX_HOLD);

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// +----------------------------------------------------------------------+
// | rr_pick  : combinational rotating priority encoder (start at last+1) |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
`default_nettype none

module rr_pick
  import mux_arb_pkg::*;
(
  input  logic [N-1:0]    i_req,
  input  logic            i_mask_vld,
  input  logic [SELW-1:0] i_mask_idx,
  input  logic [SELW-1:0] i_last,
  output logic            o_any,
  output logic [SELW-1:0] o_win
);

  localparam logic [N-1:0] c_one = N'(1);

  logic [N-1:0]    w_mask;
  logic [N-1:0]    w_req_m;
  logic [SELW-1:0] w_start;
  logic [2*N-1:0]  w_dbl;
  logic [2*N-1:0]  w_rot;
  logic [SELW-1:0] w_off;

  assign w_mask  = i_mask_vld ? (c_one << i_mask_idx) : '0;
  assign w_req_m = i_req & ~w_mask;
  assign w_start = i_last + SELW'(1);

  // Two copies back to back so a plain shift gives the wrapped scan order.
  assign w_dbl = {w_req_m, w_req_m};
  assign w_rot = w_dbl >> w_start;

  always_comb begin
    w_off = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        w_off = SELW'(i);
      end
    end
  end

  assign o_any = |w_req_m;
  // N == 2**SELW, so the SELW-bit sum wraps modulo N for free.
  assign o_win = w_start + w_off;

endmodule

`default_nettype wire

// File: rtl/mux_sel_rr_arbiter.sv
// +----------------------------------------------------------------------+
// | mux_sel_rr_arbiter : round-robin owner of a shared 32:1 mux select   |
// | Revision           : 1.0                                             |
// +----------------------------------------------------------------------+
`default_nettype none

module mux_sel_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_en,
  input  logic [N-1:0]    i_req,
  output logic [SELW-1:0] o_sel,
  output logic [N-1:0]    o_gnt,
  output logic            o_gnt_valid
);

  localparam int             HCW        = hold_w(MAX_HOLD);
  localparam logic [HCW-1:0] c_hold_max = HCW'(MAX_HOLD);
  localparam logic [HCW-1:0] c_hold_one = HCW'(1);
  localparam logic           c_hold_lim = (MAX_HOLD != 0);
  localparam logic [N-1:0]   c_one      = N'(1);

  state_t          r_state, w_state_nxt;
  logic [SELW-1:0] r_sel, w_sel_nxt;
  logic [N-1:0]    r_gnt, w_gnt_nxt;
  logic            r_gnt_valid, w_gnt_valid_nxt;
  logic [HCW-1:0]  r_hold, w_hold_nxt;
  logic [SELW-1:0] r_last, w_last_nxt;

  logic            w_own_req;
  logic            w_mask_vld;
  logic            w_any;
  logic [SELW-1:0] w_win;
  logic            w_take;

  assign w_own_req  = i_req[r_sel];
  assign w_mask_vld = (r_state == GRANT);

  rr_pick u_pick (
    .i_req      (i_req),
    .i_mask_vld (w_mask_vld),
    .i_mask_idx (r_sel),
    .i_last     (r_last),
    .o_any      (w_any),
    .o_win      (w_win)
  );

  always_comb begin
    w_state_nxt     = r_state;
    w_sel_nxt       = r_sel;
    w_gnt_nxt       = r_gnt;
    w_gnt_valid_nxt = r_gnt_valid;
    w_hold_nxt      = r_hold;
    w_last_nxt      = r_last;
    w_take          = 1'b0;

    case (r_state)
      IDLE: begin
        if (i_en && w_any) begin
          w_take = 1'b1;
        end
      end
      GRANT: begin
        if (!w_own_req) begin
          if (i_en && w_any) begin
            w_take = 1'b1;
          end else begin
            w_state_nxt     = IDLE;
            w_gnt_nxt       = '0;
            w_gnt_valid_nxt = 1'b0;
          end
        end else if (c_hold_lim && (r_hold == c_hold_max)) begin
          // Preempt only when someone else can take over; else restart the window.
          if (i_en && w_any) begin
            w_take = 1'b1;
          end else begin
            w_hold_nxt = c_hold_one;
          end
        end else if (c_hold_lim && (r_hold < c_hold_max)) begin
          w_hold_nxt = r_hold + c_hold_one;
        end
      end
      default: begin
        w_state_nxt     = IDLE;
        w_gnt_nxt       = '0;
        w_gnt_valid_nxt = 1'b0;
      end
    endcase

    if (w_take) begin
      w_state_nxt     = GRANT;
      w_sel_nxt       = w_win;
      w_gnt_nxt       = c_one << w_win;
      w_gnt_valid_nxt = 1'b1;
      w_hold_nxt      = c_hold_one;
      w_last_nxt      = w_win;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_sel       <= '0;
      r_gnt       <= '0;
      r_gnt_valid <= 1'b0;
      r_hold      <= '0;
      r_last      <= SELW'(N - 1);
    end else begin
      r_state     <= w_state_nxt;
      r_sel       <= w_sel_nxt;
      r_gnt       <= w_gnt_nxt;
      r_gnt_valid <= w_gnt_valid_nxt;
      r_hold      <= w_hold_nxt;
      r_last      <= w_last_nxt;
    end
  end

  assign o_sel       = r_sel;
  assign o_gnt       = r_gnt;
  assign o_gnt_valid = r_gnt_valid;

endmodule

`default_nettype wire
